proc_ctrl_fsm: RTL and testbench

Parametrised multi-cycle control sequencer for the instruction processor. Successor to the fixed-latency controller: handles a ready/ack memory handshake with variable latency, a memory-wait timeout, streamed program loading with a configurable boot address, and a sticky error state. Drives PC, the instruction register, the register-file write strobe and memory requests. The external decoder, ALU and register file sit alongside it in the processor top level.

---
 rtl/proc_pkg.sv | 34 +++
 rtl/mem_wait_timer.sv | 42 ++++
 rtl/proc_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle instruction controller.
// Contents:
//   state_t      - controller state encoding
//   OP_STORE     - opcode of the store instruction
//   OP_LOAD      - opcode of the load instruction
//   opcode_of()  - extracts the 4-bit opcode from the top of an instruction word
package proc_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD_WR    = 4'd1,
        FETCH      = 4'd2,
        DECODE     = 4'd3,
        EXECUTE    = 4'd4,
        MEM_WR     = 4'd5,
        MEM_RD     = 4'd6,
        WRITE_BACK = 4'd7,
        HALT       = 4'd8,
        ERROR      = 4'd9
    } state_t;

    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;

    // Widest instruction word the helper below can handle; callers
    // zero-extend their word to this width and pass the real width.
    localparam int MAX_WORD_WIDTH = 128;

    function automatic logic [3:0] opcode_of(input logic [MAX_WORD_WIDTH-1:0] word,
                                             input int width);
        return word[width-1 -: 4];
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog for the controller's request states.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - restart the wait count (no request pending, or ack seen)
//   count       - a request is pending this cycle without an ack
//   expired     - this is the MEM_TIMEOUT-th consecutive unacknowledged cycle
// MEM_TIMEOUT = 0 builds no counter and never expires.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, count};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            logic [CW-1:0] wait_count;

            // Expiry is flagged combinationally in the cycle that would bring
            // the count to MEM_TIMEOUT, so an ack in that same cycle still wins
            // (the controller checks ack before expired).
            assign expired = count && (wait_count == CW'(MEM_TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    wait_count <= '0;
                end else if (count && !expired) begin
                    wait_count <= wait_count + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control sequencer for the instruction processor.
// Streams a program into memory, then runs fetch/decode/execute/memory/
// write-back with a ready/ack memory handshake and a wait timeout.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   load_valid/data/last, load_ready - program load stream
//   mem_req/we/addr/wdata, mem_ack/rdata - memory handshake
//   ls_addr, dest_is_reg          - from the external decoder
//   alu_result, alu_branch_valid, alu_halt - from the external ALU
//   instr, opcode                 - instruction register and its opcode field
//   rf_we, rf_wdata               - register-file write port
//   pc, halted, error             - status
//   cycle_count, retired_count    - performance counters
// Optional feature macro: PROC_PERF_EN builds the performance counters;
// without it both counter ports are tied to zero.
module proc_ctrl_fsm
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BOOT_ADDR = '0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic [ADDRESS_WIDTH-1:0] ls_addr,
    input  logic                     dest_is_reg,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    input  logic                     alu_branch_valid,
    input  logic                     alu_halt,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [3:0]               opcode,
    output logic                     rf_we,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     halted,
    output logic                     error,
    output logic [31:0]              cycle_count,
    output logic [31:0]              retired_count
);

    state_t state, next_state;

    logic [ADDRESS_WIDTH-1:0]  load_ptr;
    logic [DATA_WIDTH-1:0]     load_word;
    logic                      load_last_q;
    logic [DATA_WIDTH-1:0]     exec_result;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic [MAX_WORD_WIDTH-1:0] instr_ext;
    logic                      in_req_state;
    logic                      timer_expired;

    assign instr_ext = MAX_WORD_WIDTH'(instr);
    assign opcode    = opcode_of(instr_ext, DATA_WIDTH);
    assign rf_wdata  = (opcode == OP_LOAD) ? wb_data : exec_result;

    // Derived from state alone so the timer does not loop back through
    // the next-state logic that consumes its expiry flag.
    assign in_req_state = (state == LOAD_WR) || (state == FETCH) ||
                          (state == MEM_WR)  || (state == MEM_RD);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_req_state || mem_ack),
        .count  (in_req_state && !mem_ack),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request states always test ack before the timeout so a completion in
    // the final allowed cycle is honoured.
    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rf_we      = 1'b0;
        halted     = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) next_state = LOAD_WR;
            end
            LOAD_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = load_ptr;
                mem_wdata = load_word;
                if (mem_ack) begin
                    if (load_last_q)    next_state = FETCH;
                    else if (&load_ptr) next_state = ERROR;
                    else                next_state = IDLE;
                end else if (timer_expired) begin
                    next_state = ERROR;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack)            next_state = DECODE;
                else if (timer_expired) next_state = ERROR;
            end
            DECODE: next_state = EXECUTE;
            EXECUTE: begin
                if (alu_halt)                next_state = HALT;
                else if (opcode == OP_STORE) next_state = MEM_WR;
                else if (opcode == OP_LOAD)  next_state = MEM_RD;
                else                         next_state = WRITE_BACK;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ls_addr;
                mem_wdata = exec_result;
                if (mem_ack)            next_state = WRITE_BACK;
                else if (timer_expired) next_state = ERROR;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = ls_addr;
                if (mem_ack)            next_state = WRITE_BACK;
                else if (timer_expired) next_state = ERROR;
            end
            WRITE_BACK: begin
                rf_we      = dest_is_reg && (opcode != OP_STORE);
                next_state = FETCH;
            end
            HALT:  halted = 1'b1;
            ERROR: error  = 1'b1;
            default: next_state = ERROR;
        endcase
    end

    // Datapath registers, updated according to the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= BOOT_ADDR;
            load_ptr    <= BOOT_ADDR;
            load_word   <= '0;
            load_last_q <= 1'b0;
            instr       <= '0;
            exec_result <= '0;
            wb_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        load_word   <= load_data;
                        load_last_q <= load_last;
                    end
                end
                LOAD_WR: begin
                    if (mem_ack) begin
                        load_ptr <= load_ptr + 1'b1;
                        if (load_last_q) pc <= BOOT_ADDR;
                    end
                end
                FETCH: begin
                    if (mem_ack) instr <= mem_rdata;
                end
                EXECUTE: exec_result <= alu_result;
                MEM_RD: begin
                    if (mem_ack) wb_data <= mem_rdata;
                end
                WRITE_BACK: begin
                    pc <= alu_branch_valid ? exec_result[ADDRESS_WIDTH-1:0] : pc + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PROC_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] retired_q;

    // Cycles count only while a program is running; retirement counts each
    // write-back plus the halting instruction itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (!((state == IDLE) || (state == LOAD_WR) || (state == HALT) || (state == ERROR)))
                cycle_q <= cycle_q + 1'b1;
            if ((state == WRITE_BACK) || ((state != HALT) && (next_state == HALT)))
                retired_q <= retired_q + 1'b1;
        end
    end

    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
`else
    assign cycle_count   = '0;
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed self-checking bench for proc_ctrl_fsm (MEM_TIMEOUT = 4).
// The bench plays memory, decoder and ALU by hand; expected counter values
// depend on whether PROC_PERF_EN is defined.
module tb_proc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [11:0] ls_addr = '0;
    logic        dest_is_reg = 1'b0;
    logic [31:0] alu_result = '0;
    logic        alu_branch_valid = 1'b0;
    logic        alu_halt = 1'b0;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [11:0] pc;
    logic        halted;
    logic        error;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;

    int checks = 0;
    int failures = 0;

    proc_ctrl_fsm #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(12),
        .BOOT_ADDR(12'h000),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ls_addr(ls_addr), .dest_is_reg(dest_is_reg),
        .alu_result(alu_result), .alu_branch_valid(alu_branch_valid), .alu_halt(alu_halt),
        .instr(instr), .opcode(opcode), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .pc(pc), .halted(halted), .error(error),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One program beat from IDLE, acked in its first LOAD_WR cycle.
    task automatic load_beat(input logic [31:0] data, input logic last, input logic [11:0] exp_addr);
        load_valid = 1'b1; load_data = data; load_last = last;
        #1;
        checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL beat_ready_idle: got %b expected 1", load_ready); end
        step();
        load_valid = 1'b0; load_last = 1'b0; mem_ack = 1'b1;
        #1;
        checks++; if ({mem_req, mem_we, load_ready} !== 3'b110) begin failures++; $display("[TB] FAIL beat_ctrl: req/we/ready got %b expected 110", {mem_req, mem_we, load_ready}); end
        checks++; if (mem_addr !== exp_addr) begin failures++; $display("[TB] FAIL beat_addr: got %h expected %h", mem_addr, exp_addr); end
        checks++; if (mem_wdata !== data) begin failures++; $display("[TB] FAIL beat_wdata: got %h expected %h", mem_wdata, data); end
        step();
        mem_ack = 1'b0;
    endtask

    // Zero-wait fetch; returns in DECODE.
    task automatic fetch_ack(input logic [31:0] rdata, input logic [11:0] exp_pc);
        mem_ack = 1'b1; mem_rdata = rdata;
        #1;
        checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== exp_pc) begin failures++; $display("[TB] FAIL fetch_req: req/we=%b addr=%h expected 10 addr=%h", {mem_req, mem_we}, mem_addr, exp_pc); end
        step();
        mem_ack = 1'b0;
        #1;
        checks++; if (instr !== rdata) begin failures++; $display("[TB] FAIL fetch_instr: got %h expected %h", instr, rdata); end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (pc !== 12'h000) begin failures++; $display("[TB] FAIL reset_pc: got %h expected 000", pc); end
        checks++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
        checks++; if ({mem_req, mem_we, rf_we, halted, error} !== 5'b0) begin failures++; $display("[TB] FAIL reset_outputs: got %b expected 00000", {mem_req, mem_we, rf_we, halted, error}); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", load_ready); end
        checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, retired_count); end
        reset = 1'b0;
    endtask

    task automatic test_load();
        load_beat(32'h1111_0000, 1'b0, 12'h000);
        load_beat(32'h2222_0001, 1'b0, 12'h001);
        load_beat(32'h3333_0002, 1'b1, 12'h002);
        #1;
        checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 12'h000) begin failures++; $display("[TB] FAIL load_to_fetch: req/we=%b addr=%h expected 10 addr=000", {mem_req, mem_we}, mem_addr); end
    endtask

    task automatic test_add();
        int pulses;
        pulses = 0;
        alu_result = 32'h5; dest_is_reg = 1'b1; alu_branch_valid = 1'b0; alu_halt = 1'b0;
        fetch_ack(32'h3000_0012, 12'h000);
        checks++; if (opcode !== 4'h3) begin failures++; $display("[TB] FAIL add_opcode: got %h expected 3", opcode); end
        if (rf_we) pulses++;
        step(); #1;
        if (rf_we) pulses++;
        step(); #1;
        if (rf_we) pulses++;
        checks++; if (rf_wdata !== 32'h5) begin failures++; $display("[TB] FAIL add_wdata: got %h expected 00000005", rf_wdata); end
        step(); #1;
        checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL add_rf_pulses: got %0d expected 1", pulses); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h001 || pc !== 12'h001) begin failures++; $display("[TB] FAIL add_next_fetch: req=%b addr=%h pc=%h expected 1 001 001", mem_req, mem_addr, pc); end
    endtask

    task automatic test_load_instr();
        int held;
        held = 0;
        alu_result = 32'h77; ls_addr = 12'h040; dest_is_reg = 1'b1;
        fetch_ack(32'h2000_0000, 12'h001);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
            #1;
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 12'h040) held++;
            step();
        end
        mem_ack = 1'b0;
        #1;
        checks++; if (held != 3) begin failures++; $display("[TB] FAIL ld_req_held: got %0d cycles expected 3", held); end
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL ld_writeback: we=%b data=%h expected 1 deadbeef", rf_we, rf_wdata); end
        step(); #1;
        checks++; if (mem_addr !== 12'h002) begin failures++; $display("[TB] FAIL ld_next_pc: got %h expected 002", mem_addr); end
    endtask

    task automatic test_store();
        alu_result = 32'h1234_5678; ls_addr = 12'h055; dest_is_reg = 1'b1;
        fetch_ack(32'h1000_0000, 12'h002);
        step();
        step();
        mem_ack = 1'b1;
        #1;
        checks++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 12'h055 || mem_wdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL st_req: req/we=%b addr=%h data=%h expected 11 055 12345678", {mem_req, mem_we}, mem_addr, mem_wdata); end
        step();
        mem_ack = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL st_no_rf_we: got %b expected 0", rf_we); end
        step(); #1;
        checks++; if (mem_addr !== 12'h003) begin failures++; $display("[TB] FAIL st_next_pc: got %h expected 003", mem_addr); end
    endtask

    task automatic test_branch_halt();
        int busy;
        logic [31:0] exp_cycles, exp_retired;
        busy = 0;
        alu_result = 32'h0A0; alu_branch_valid = 1'b1; dest_is_reg = 1'b0;
        fetch_ack(32'h3000_0000, 12'h003);
        step();
        step(); #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL br_rf_we: got %b expected 0", rf_we); end
        step(); #1;
        checks++; if (mem_addr !== 12'h0A0 || pc !== 12'h0A0) begin failures++; $display("[TB] FAIL br_target: addr=%h pc=%h expected 0a0", mem_addr, pc); end
        alu_branch_valid = 1'b0; alu_halt = 1'b1;
        fetch_ack(32'h3000_0000, 12'h0A0);
        step();
        step();
        alu_halt = 1'b0;
        #1;
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_flag: got %b expected 1", halted); end
        for (int i = 0; i < 20; i++) begin
            if (mem_req !== 1'b0) busy++;
            step();
        end
        checks++; if (busy != 0 || halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_quiet: req cycles=%0d halted=%b expected 0 1", busy, halted); end
`ifdef PROC_PERF_EN
        exp_cycles = 32'd23; exp_retired = 32'd5;
`else
        exp_cycles = 32'd0; exp_retired = 32'd0;
`endif
        checks++; if (cycle_count !== exp_cycles) begin failures++; $display("[TB] FAIL perf_cycles: got %0d expected %0d", cycle_count, exp_cycles); end
        checks++; if (retired_count !== exp_retired) begin failures++; $display("[TB] FAIL perf_retired: got %0d expected %0d", retired_count, exp_retired); end
    endtask

    task automatic test_timeout();
        int waiting;
        waiting = 0;
        do_reset();
        load_beat(32'hAAAA_0000, 1'b1, 12'h000);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (mem_req === 1'b1 && error === 1'b0) waiting++;
            step();
        end
        #1;
        checks++; if (waiting != 4) begin failures++; $display("[TB] FAIL to_wait_cycles: got %0d expected 4", waiting); end
        checks++; if (error !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL to_error: error=%b req=%b expected 1 0", error, mem_req); end
        step(); step(); #1;
        checks++; if (error !== 1'b1 || load_ready !== 1'b0) begin failures++; $display("[TB] FAIL to_sticky: error=%b ready=%b expected 1 0", error, load_ready); end
    endtask

    // Ack on the last allowed cycle survives; then reset lands mid MEM_RD.
    task automatic test_ack_at_limit_and_reset();
        do_reset();
        load_beat(32'hBBBB_0000, 1'b1, 12'h000);
        ls_addr = 12'h040; dest_is_reg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'h2000_0000; end
            step();
        end
        mem_ack = 1'b0;
        #1;
        checks++; if (error !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL late_ack_ok: error=%b req=%b expected 0 0", error, mem_req); end
        step();
        step(); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h040) begin failures++; $display("[TB] FAIL rd_before_reset: req=%b addr=%h expected 1 040", mem_req, mem_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (load_ready !== 1'b1 || mem_req !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_idle: ready/req/we=%b expected 100", {load_ready, mem_req, rf_we}); end
        checks++; if (pc !== 12'h000 || instr !== 32'h0) begin failures++; $display("[TB] FAIL mid_reset_regs: pc=%h instr=%h expected 000 0", pc, instr); end
        checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin failures++; $display("[TB] FAIL mid_reset_counters: got %0d/%0d expected 0/0", cycle_count, retired_count); end
        step(); #1;
        checks++; if (rf_we !== 1'b0 || load_ready !== 1'b1 || error !== 1'b0) begin failures++; $display("[TB] FAIL late_ack_ignored: we/ready/err=%b expected 010", {rf_we, load_ready, error}); end
        mem_ack = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4095; i++) begin
            load_beat(32'(i), 1'b0, 12'(i));
        end
        #1;
        checks++; if (error !== 1'b0 || load_ready !== 1'b1) begin failures++; $display("[TB] FAIL ovf_before: error=%b ready=%b expected 0 1", error, load_ready); end
        load_beat(32'h0000_0FFF, 1'b0, 12'hFFF);
        #1;
        checks++; if (error !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL ovf_error: error=%b req=%b expected 1 0", error, mem_req); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_load_instr();
        test_store();
        test_branch_halt();
        test_timeout();
        test_ack_at_limit_and_reset();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
